// File: rtl/ffs_buzzer_latch_if.sv
// Signal bundle between the player-button front end and its environment.
// When FFS_FOUL_DETECT_EN is defined the bundle also carries the foul_n vector.
interface ffs_buzzer_latch_if #(
  parameter int N_BUTTONS = 10
);

  logic [N_BUTTONS-1:0] btn_n;
  logic                 arm;
  logic                 clear;
  logic [N_BUTTONS-1:0] locked_n;
  logic                 winner_valid;
  logic                 timeout;
  logic [1:0]           state;
`ifdef FFS_FOUL_DETECT_EN
  logic [N_BUTTONS-1:0] foul_n;
`endif

`ifdef FFS_FOUL_DETECT_EN
  modport master (
    output btn_n, arm, clear,
    input  locked_n, winner_valid, timeout, state, foul_n
  );

  modport slave (
    input  btn_n, arm, clear,
    output locked_n, winner_valid, timeout, state, foul_n
  );
`else
  modport master (
    output btn_n, arm, clear,
    input  locked_n, winner_valid, timeout, state
  );

  modport slave (
    input  btn_n, arm, clear,
    output locked_n, winner_valid, timeout, state
  );
`endif

endinterface

// File: rtl/ffs_buzzer_latch.sv
// Buzzer front end: sync + debounce of active-low buttons, first-press capture and lockout.
// Optional early-press foul tracking is enabled by defining FFS_FOUL_DETECT_EN.
module ffs_buzzer_latch #(
  parameter int N_BUTTONS       = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  ffs_buzzer_latch_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    LOCKED = 2'b10
  } state_e;

  logic [N_BUTTONS-1:0] sync1_q;
  logic [N_BUTTONS-1:0] sync2_q;
  logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
  logic [CNT_W-1:0]     cnt_d [N_BUTTONS];
  logic [N_BUTTONS-1:0] db;
  logic [N_BUTTONS-1:0] db_d_q;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] cand;
  logic [N_BUTTONS-1:0] win_oh;
  logic                 any_cand;
  logic                 expire;

  state_e               state_q;
  logic [N_BUTTONS-1:0] locked_n_q;
  logic                 winner_valid_q;
  logic                 timeout_q;
  logic [TMO_W-1:0]     tmo_q;

  // Sync flops preset high so a reset looks like every button released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.btn_n;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != DB_MAX) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      db[i] = (cnt_q[i] == DB_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
      db_d_q <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      db_d_q <= db;
    end
  end

  assign rise = db & ~db_d_q;

`ifdef FFS_FOUL_DETECT_EN
  logic [N_BUTTONS-1:0] foul_n_q;
  assign cand       = rise & foul_n_q;
  assign bus.foul_n = foul_n_q;
`else
  assign cand = rise;
`endif

  // Lowest index wins so simultaneous presses agree with the downstream encoder.
  always_comb begin
    win_oh = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_oh = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign any_cand = |cand;
  assign expire   = (state_q == ARMED) && !bus.clear && !any_cand && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      locked_n_q     <= '1;
      winner_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      tmo_q          <= '0;
`ifdef FFS_FOUL_DETECT_EN
      foul_n_q       <= '1;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.arm && !bus.clear) begin
            state_q <= ARMED;
            tmo_q   <= '0;
          end
        end
        ARMED: begin
          if (bus.clear) begin
            state_q <= IDLE;
          end else if (any_cand) begin
            state_q        <= LOCKED;
            locked_n_q     <= ~win_oh;
            winner_valid_q <= 1'b1;
          end else if (expire) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        LOCKED: begin
          if (bus.clear) begin
            state_q        <= IDLE;
            locked_n_q     <= '1;
            winner_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= IDLE;
          locked_n_q     <= '1;
          winner_valid_q <= 1'b0;
        end
      endcase
`ifdef FFS_FOUL_DETECT_EN
      // Anyone already pressed before or at the arm edge sits out the round.
      if (bus.clear || expire) begin
        foul_n_q <= '1;
      end else if (state_q == IDLE) begin
        foul_n_q <= foul_n_q & ~db;
      end
`endif
    end
  end

  assign bus.locked_n     = locked_n_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_ffs_buzzer_latch.sv
// Self-checking bench for ffs_buzzer_latch: directed rounds followed by random button traffic,
// compared every cycle against a run-length based behavioural model.
module tb_ffs_buzzer_latch;

  localparam int NB  = 10;
  localparam int DB  = 4;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ffs_buzzer_latch_if #(.N_BUTTONS(NB)) bus ();

  ffs_buzzer_latch #(
    .N_BUTTONS(NB),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Model state: 0 idle, 1 armed, 2 locked.
  int mState;
  int armedAge;
  int winner;
  bit expTimeout;
  int hist [NB][3];
  bit fouled [NB];

  int nChecks = 0;
  int nFails  = 0;

  task automatic modelReset();
    mState     = 0;
    armedAge   = 0;
    winner     = -1;
    expTimeout = 1'b0;
    for (int i = 0; i < NB; i++) begin
      fouled[i] = 1'b0;
      for (int k = 0; k < 3; k++) hist[i][k] = 0;
    end
  endtask

  // hist[i][k] is the run of consecutive low samples of button i as of k+1 edges ago.
  // A press reaches the FSM three edges after its run first hits DB.
  task automatic modelEdge();
    int first;
`ifdef FFS_FOUL_DETECT_EN
    int pre;
`endif
    if (rst) begin
      modelReset();
      return;
    end
`ifdef FFS_FOUL_DETECT_EN
    pre = mState;
`endif
    first = -1;
    for (int i = NB - 1; i >= 0; i--) begin
      if (hist[i][2] == DB && !fouled[i]) first = i;
    end
    expTimeout = 1'b0;
    case (mState)
      0: begin
        if (bus.arm && !bus.clear) begin
          mState   = 1;
          armedAge = 0;
        end
      end
      1: begin
        armedAge++;
        if (bus.clear) begin
          mState = 0;
        end else if (first >= 0) begin
          mState = 2;
          winner = first;
        end else if (armedAge == TMO) begin
          mState     = 0;
          expTimeout = 1'b1;
        end
      end
      default: begin
        if (bus.clear) begin
          mState = 0;
          winner = -1;
        end
      end
    endcase
`ifdef FFS_FOUL_DETECT_EN
    for (int i = 0; i < NB; i++) begin
      if (bus.clear || expTimeout) fouled[i] = 1'b0;
      else if (pre == 0 && hist[i][2] >= DB) fouled[i] = 1'b1;
    end
`endif
    for (int i = 0; i < NB; i++) begin
      hist[i][2] = hist[i][1];
      hist[i][1] = hist[i][0];
      if (bus.btn_n[i]) hist[i][0] = 0;
      else hist[i][0] = (hist[i][1] > DB) ? DB + 1 : hist[i][1] + 1;
    end
  endtask

  task automatic checkOutput(string tag);
    logic [NB-1:0] expLocked;
    expLocked = '1;
    if (mState == 2) expLocked[winner] = 1'b0;
    nChecks++;
    assert (bus.locked_n === expLocked) else begin
      nFails++;
      $error("[TB] FAIL %s locked_n observed=%b expected=%b", tag, bus.locked_n, expLocked);
    end
    nChecks++;
    assert (bus.winner_valid === (mState == 2)) else begin
      nFails++;
      $error("[TB] FAIL %s winner_valid observed=%b expected=%b", tag, bus.winner_valid, (mState == 2));
    end
    nChecks++;
    assert (bus.timeout === expTimeout) else begin
      nFails++;
      $error("[TB] FAIL %s timeout observed=%b expected=%b", tag, bus.timeout, expTimeout);
    end
    nChecks++;
    assert (bus.state === 2'(mState)) else begin
      nFails++;
      $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, bus.state, mState);
    end
`ifdef FFS_FOUL_DETECT_EN
    begin
      logic [NB-1:0] expFoul;
      for (int i = 0; i < NB; i++) expFoul[i] = ~fouled[i];
      nChecks++;
      assert (bus.foul_n === expFoul) else begin
        nFails++;
        $error("[TB] FAIL %s foul_n observed=%b expected=%b", tag, bus.foul_n, expFoul);
      end
    end
`endif
  endtask

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic applyStimulus(logic [NB-1:0] btn, logic a, logic c, int n, string tag);
    bus.btn_n = btn;
    bus.arm   = a;
    bus.clear = c;
    repeat (n) cycle(tag);
  endtask

  initial begin
    logic [NB-1:0] b;
    logic a;
    logic c;
    int pulses;

    bus.btn_n = '1;
    bus.arm   = 1'b0;
    bus.clear = 1'b0;
    modelReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset");
    checkVal("reset_locked", 32'(bus.locked_n), 32'h3FF);
    rst = 1'b0;
    applyStimulus('1, 1'b0, 1'b0, 2, "idle");

    // Single press on player 3, exact capture edge, later press ignored.
    applyStimulus('1, 1'b1, 1'b0, 1, "arm1");
    b = '1; b[3] = 1'b0;
    applyStimulus(b, 1'b0, 1'b0, 6, "p3_wait");
    checkVal("p3_not_yet", 32'(bus.locked_n), 32'h3FF);
    applyStimulus(b, 1'b0, 1'b0, 1, "p3_edge");
    checkVal("p3_locked", 32'(bus.locked_n), 32'b11_1111_0111);
    checkVal("p3_valid", 32'(bus.winner_valid), 32'd1);
    b[5] = 1'b0;
    applyStimulus(b, 1'b0, 1'b0, 10, "p5_late");
    checkVal("p5_ignored", 32'(bus.locked_n), 32'b11_1111_0111);
    applyStimulus('1, 1'b0, 1'b0, 6, "rel1");
    applyStimulus('1, 1'b0, 1'b1, 1, "clr1");
    applyStimulus('1, 1'b0, 1'b0, 2, "idle1");

    // Simultaneous presses resolve to the lower index.
    applyStimulus('1, 1'b1, 1'b0, 1, "arm2");
    b = '1; b[2] = 1'b0; b[7] = 1'b0;
    applyStimulus(b, 1'b0, 1'b0, 8, "p2p7");
    checkVal("p2p7_locked", 32'(bus.locked_n), 32'b11_1111_1011);
    applyStimulus('1, 1'b0, 1'b0, 6, "rel2");
    applyStimulus('1, 1'b0, 1'b1, 1, "clr2");
    checkVal("clr2_locked", 32'(bus.locked_n), 32'h3FF);
    checkVal("clr2_state", 32'(bus.state), 32'd0);
    applyStimulus('1, 1'b0, 1'b0, 2, "idle2");

    // Short glitches never reach the debounce threshold.
    applyStimulus('1, 1'b1, 1'b0, 1, "arm3");
    repeat (4) begin
      b = '1; b[1] = 1'b0;
      applyStimulus(b, 1'b0, 1'b0, 3, "glitch_lo");
      applyStimulus('1, 1'b0, 1'b0, 3, "glitch_hi");
    end
    checkVal("glitch_state", 32'(bus.state), 32'd1);
    checkVal("glitch_locked", 32'(bus.locked_n), 32'h3FF);
    applyStimulus('1, 1'b0, 1'b1, 1, "clr3");
    applyStimulus('1, 1'b0, 1'b0, 2, "idle3");

    // Quiet round expires with exactly one timeout pulse.
    applyStimulus('1, 1'b1, 1'b0, 1, "arm4");
    pulses = 0;
    repeat (60) begin
      applyStimulus('1, 1'b0, 1'b0, 1, "tmo");
      if (bus.timeout) pulses++;
    end
    checkVal("tmo_pulses", 32'(pulses), 32'd1);
    checkVal("tmo_state", 32'(bus.state), 32'd0);
    b = '1; b[0] = 1'b0;
    applyStimulus(b, 1'b0, 1'b0, 8, "p0_after_tmo");
    checkVal("p0_ignored", 32'(bus.locked_n), 32'h3FF);
    applyStimulus('1, 1'b0, 1'b0, 6, "rel4");

    // Button held through arm is not a new press; a re-press is.
    b = '1; b[4] = 1'b0;
    applyStimulus(b, 1'b0, 1'b0, 10, "p4_early");
    applyStimulus(b, 1'b1, 1'b0, 1, "arm5");
    applyStimulus(b, 1'b0, 1'b0, 8, "p4_held");
    checkVal("p4_held_state", 32'(bus.state), 32'd1);
    applyStimulus('1, 1'b0, 1'b0, 4, "p4_release");
    applyStimulus(b, 1'b0, 1'b0, 8, "p4_repress");
`ifdef FFS_FOUL_DETECT_EN
    checkVal("p4_fouled", 32'(bus.foul_n[4]), 32'd0);
    checkVal("p4_excluded", 32'(bus.state), 32'd1);
`else
    checkVal("p4_captured", 32'(bus.locked_n), 32'b11_1110_1111);
`endif
    applyStimulus('1, 1'b0, 1'b0, 6, "rel5");
    applyStimulus('1, 1'b0, 1'b1, 1, "clr5");
    applyStimulus('1, 1'b0, 1'b0, 3, "idle5");

    // Asynchronous reset while locked on player 9.
    applyStimulus('1, 1'b1, 1'b0, 1, "arm6");
    b = '1; b[9] = 1'b0;
    applyStimulus(b, 1'b0, 1'b0, 8, "p9");
    checkVal("p9_locked", 32'(bus.locked_n), 32'b01_1111_1111);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_async");
    checkVal("rst_async_locked", 32'(bus.locked_n), 32'h3FF);
    checkVal("rst_async_state", 32'(bus.state), 32'd0);
    bus.btn_n = '1;
    cycle("rst_hold");
    rst = 1'b0;
    applyStimulus('1, 1'b0, 1'b0, 3, "idle6");

    // Random button traffic with occasional arm and clear pulses.
    b = '1;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
      end
      a = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 39) == 0);
      applyStimulus(b, a, c, 1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
